// File: rtl/hdc_class_trainer.sv
`default_nettype none
// ============================================================================
// Module   : hdc_class_trainer
// Purpose  : Builds ham/spam class hypervectors for the HDC spam classifier.
//            Labeled, pre-encoded binary hypervectors arrive CHUNK bits per
//            beat and are bundled into per-dimension saturating counters
//            (one set per class). On finalize, the counters are thresholded
//            and streamed out, ham first and then spam.
// Ports    : clk, rst                      - clock, sync active-high reset
//            in_valid/in_ready/in_bits/
//            in_label/in_last              - training beat stream
//            finalize, clr                 - readout request, counter clear
//            out_valid/out_ready/out_bits/
//            out_class/out_last            - class-vector readout stream
//            done                          - pulse after last readout beat
//            ham_count, spam_count         - messages accumulated per class
//            proto_err                     - sticky framing error
// Revision : 1.0 - initial release
// ============================================================================
module hdc_class_trainer #(
  parameter int DIM   = 1024,
  parameter int CHUNK = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHUNK-1:0] in_bits,
  input  logic             in_label,
  input  logic             in_last,
  input  logic             finalize,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_bits,
  output logic             out_class,
  output logic             out_last,
  output logic             done,
  output logic [15:0]      ham_count,
  output logic [15:0]      spam_count,
  output logic             proto_err
);

  localparam int BEATS = DIM / CHUNK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  // Symmetric saturation limits: +/-(2^(CNT_W-1)-1)
  localparam logic signed [CNT_W-1:0] CMAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CMIN = -CMAX;

  localparam logic [1:0] ST_ACC = 2'd0;
  localparam logic [1:0] ST_OUT = 2'd1;
  localparam logic [1:0] ST_CLR = 2'd2;

  logic [1:0]    state;
  logic [BW-1:0] beat;
  logic          label_q;
  logic          fin_pend;
  logic          out_cls;
  logic [BW-1:0] out_beat;
  logic [BW-1:0] clr_idx;

  logic signed [CNT_W-1:0] cnt [2][BEATS][CHUNK];

  logic acc;
  logic eff_label;

  // Label is taken live on beat 0, latched copy for the remaining beats
  assign eff_label = (beat == '0) ? in_label : label_q;
  assign in_ready  = (state == ST_ACC);
  assign acc       = in_ready & in_valid & ~clr;
  assign out_valid = (state == ST_OUT);
  assign out_class = out_cls;
  assign out_last  = out_cls & (out_beat == BEAT_LAST);

  function automatic logic signed [CNT_W-1:0] sat_step(
    input logic signed [CNT_W-1:0] c,
    input logic                    up
  );
    if (up) return (c == CMAX) ? c : c + CNT_W'(1);
    else    return (c == CMIN) ? c : c - CNT_W'(1);
  endfunction

  // Threshold: positive -> 1, negative -> 0, zero -> LSB of dimension index
  always_comb begin
    out_bits = '0;
    for (int k = 0; k < CHUNK; k++) begin
      if (cnt[out_cls][out_beat][k][CNT_W-1])
        out_bits[k] = 1'b0;
      else if (|cnt[out_cls][out_beat][k])
        out_bits[k] = 1'b1;
      else
        out_bits[k] = (CHUNK % 2 == 0) ? k[0] : (k[0] ^ out_beat[0]);
    end
  end

  // Counter storage: accumulate in ACC, wipe one chunk per cycle in CLR
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++)
        for (int b = 0; b < BEATS; b++)
          for (int k = 0; k < CHUNK; k++)
            cnt[c][b][k] <= '0;
    end else if (state == ST_CLR) begin
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < CHUNK; k++)
          cnt[c][clr_idx][k] <= '0;
    end else if (acc) begin
      for (int k = 0; k < CHUNK; k++)
        cnt[eff_label][beat][k] <= sat_step(cnt[eff_label][beat][k], in_bits[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACC;
      beat       <= '0;
      label_q    <= 1'b0;
      fin_pend   <= 1'b0;
      out_cls    <= 1'b0;
      out_beat   <= '0;
      clr_idx    <= '0;
      done       <= 1'b0;
      ham_count  <= '0;
      spam_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (finalize) fin_pend <= 1'b1;
      if (clr) begin
        state    <= ST_CLR;
        clr_idx  <= '0;
        fin_pend <= 1'b0;
      end else begin
        case (state)
          ST_ACC: begin
            if (acc) begin
              if (beat == '0) label_q <= in_label;
              if (in_last) begin
                if (beat != BEAT_LAST) proto_err <= 1'b1;
                beat <= '0;
                if (eff_label) begin
                  if (spam_count != 16'hFFFF) spam_count <= spam_count + 16'd1;
                end else begin
                  if (ham_count != 16'hFFFF) ham_count <= ham_count + 16'd1;
                end
              end else if (beat == BEAT_LAST) begin
                // Overlong message: resynchronise, do not count it
                proto_err <= 1'b1;
                beat      <= '0;
              end else begin
                beat <= beat + BW'(1);
              end
            end
            // Readout only starts on a message boundary
            if ((fin_pend | finalize) && beat == '0) begin
              state    <= ST_OUT;
              fin_pend <= 1'b0;
              out_cls  <= 1'b0;
              out_beat <= '0;
            end
          end
          ST_OUT: begin
            if (out_ready) begin
              if (out_last) begin
                state <= ST_ACC;
                done  <= 1'b1;
              end else if (out_beat == BEAT_LAST) begin
                out_cls  <= 1'b1;
                out_beat <= '0;
              end else begin
                out_beat <= out_beat + BW'(1);
              end
            end
          end
          ST_CLR: begin
            fin_pend <= 1'b0;
            clr_idx  <= clr_idx + BW'(1);
            if (clr_idx == BEAT_LAST) begin
              state      <= ST_ACC;
              beat       <= '0;
              ham_count  <= '0;
              spam_count <= '0;
              proto_err  <= 1'b0;
            end
          end
          default: state <= ST_ACC;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdc_class_trainer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdc_class_trainer
// Purpose  : Directed self-checking bench for hdc_class_trainer with
//            DIM=64, CHUNK=16, CNT_W=4 (4 beats per hypervector).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdc_class_trainer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_bits = '0;
  logic        in_label = 1'b0;
  logic        in_last = 1'b0;
  logic        finalize = 1'b0;
  logic        clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_bits;
  logic        out_class;
  logic        out_last;
  logic        done;
  logic [15:0] ham_count;
  logic [15:0] spam_count;
  logic        proto_err;

  int passed = 0;
  int total  = 0;

  logic [15:0] rd_bits [8];
  logic [7:0]  rd_cls;
  logic [7:0]  rd_last;
  int          rd_n;
  logic        rd_done;
  logic        rd_valid_after;

  hdc_class_trainer #(.DIM(64), .CHUNK(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .in_label(in_label), .in_last(in_last),
    .finalize(finalize), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_class(out_class), .out_last(out_last), .done(done),
    .ham_count(ham_count), .spam_count(spam_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] bits, input logic label, input logic last);
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (!in_ready) $display("FAIL in_ready_wait: in_ready=%0b required 1", in_ready);
    else passed++;
    in_valid = 1'b1; in_bits = bits; in_label = label; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_label = 1'b0;
  endtask

  task automatic send_msg(input logic label, input logic [15:0] bits);
    for (int b = 0; b < 4; b++) send_beat(bits, label, b == 3);
  endtask

  // Pulse finalize and collect up to 8 beats with out_ready held high
  task automatic readout();
    out_ready = 1'b1;
    finalize = 1'b1;
    @(posedge clk); #1;
    finalize = 1'b0;
    rd_n = 0; rd_cls = '0; rd_last = '0;
    for (int c = 0; c < 40 && rd_n < 8; c++) begin
      if (out_valid) begin
        rd_bits[rd_n] = out_bits;
        rd_cls[rd_n]  = out_class;
        rd_last[rd_n] = out_last;
        rd_n++;
      end
      @(posedge clk); #1;
    end
    rd_done = done;
    rd_valid_after = out_valid;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else passed++;
    total++; if (ham_count !== 16'd0 || spam_count !== 16'd0)
      $display("FAIL reset_counts: got %0d/%0d exp 0/0", ham_count, spam_count); else passed++;
    total++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b exp 0", proto_err); else passed++;
  endtask

  task automatic test_empty_finalize();
    do_reset();
    readout();
    total++; if (rd_n !== 8) $display("FAIL empty_beats: got %0d exp 8", rd_n); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (rd_bits[i] !== 16'hAAAA) $display("FAIL empty_bits[%0d]: got %h exp aaaa", i, rd_bits[i]); else passed++;
    end
    total++; if (rd_cls !== 8'hF0) $display("FAIL empty_class: got %b exp 11110000", rd_cls); else passed++;
    total++; if (rd_last !== 8'h80) $display("FAIL empty_last: got %b exp 10000000", rd_last); else passed++;
    total++; if (rd_done !== 1'b1 || rd_valid_after !== 1'b0)
      $display("FAIL empty_done: got done=%b valid=%b exp 1/0", rd_done, rd_valid_after); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL empty_back_to_acc: got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_ham();
    do_reset();
    send_msg(1'b0, 16'hFFFF);
    total++; if (ham_count !== 16'd1 || spam_count !== 16'd0)
      $display("FAIL ham_counts: got %0d/%0d exp 1/0", ham_count, spam_count); else passed++;
    readout();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rd_bits[i] !== ((i < 4) ? 16'hFFFF : 16'hAAAA))
        $display("FAIL ham_bits[%0d]: got %h exp %h", i, rd_bits[i], (i < 4) ? 16'hFFFF : 16'hAAAA);
      else passed++;
    end
  endtask

  task automatic test_spam();
    do_reset();
    send_msg(1'b1, 16'h00FF);
    send_msg(1'b1, 16'h00FF);
    send_msg(1'b1, 16'hFFFF);
    total++; if (spam_count !== 16'd3 || ham_count !== 16'd0)
      $display("FAIL spam_counts: got %0d/%0d exp 0/3", ham_count, spam_count); else passed++;
    readout();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rd_bits[i] !== ((i < 4) ? 16'hAAAA : 16'h00FF))
        $display("FAIL spam_bits[%0d]: got %h exp %h", i, rd_bits[i], (i < 4) ? 16'hAAAA : 16'h00FF);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int m = 0; m < 10; m++) send_msg(1'b0, 16'hFFFF);
    for (int m = 0; m < 7; m++)  send_msg(1'b0, 16'h0000);
    total++; if (ham_count !== 16'd17) $display("FAIL sat_count: got %0d exp 17", ham_count); else passed++;
    readout();
    total++; if (rd_bits[0] !== 16'hAAAA || rd_bits[3] !== 16'hAAAA)
      $display("FAIL sat_tie: got %h/%h exp aaaa", rd_bits[0], rd_bits[3]); else passed++;
    send_msg(1'b0, 16'h0000);
    readout();
    total++; if (rd_bits[0] !== 16'h0000 || rd_bits[2] !== 16'h0000)
      $display("FAIL sat_negative: got %h/%h exp 0000", rd_bits[0], rd_bits[2]); else passed++;
    total++; if (rd_bits[5] !== 16'hAAAA) $display("FAIL sat_spam_untouched: got %h exp aaaa", rd_bits[5]); else passed++;
  endtask

  task automatic test_backpressure();
    int n, hold;
    logic [15:0] hb;
    logic hc;
    do_reset();
    send_msg(1'b0, 16'hFFFF);
    out_ready = 1'b1;
    finalize = 1'b1;
    @(posedge clk); #1;
    finalize = 1'b0;
    n = 0; hold = 0; hb = '0; hc = 1'b0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      if (out_valid) begin
        if (n == 2 && hold < 3) begin
          if (hold == 0) begin
            hb = out_bits; hc = out_class;
          end else begin
            total++;
            if (out_bits !== hb || out_class !== hc)
              $display("FAIL bp_hold: got %h/%b exp %h/%b", out_bits, out_class, hb, hc);
            else passed++;
          end
          out_ready = 1'b0;
          hold++;
        end else begin
          out_ready = 1'b1;
          rd_bits[n] = out_bits;
          rd_cls[n]  = out_class;
          n++;
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    total++; if (n !== 8 || hold !== 3) $display("FAIL bp_beats: got %0d beats %0d stalls exp 8/3", n, hold); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rd_bits[i] !== ((i < 4) ? 16'hFFFF : 16'hAAAA) || rd_cls[i] !== (i >= 4))
        $display("FAIL bp_bits[%0d]: got %h/%b exp %h/%b", i, rd_bits[i], rd_cls[i],
                 (i < 4) ? 16'hFFFF : 16'hAAAA, i >= 4);
      else passed++;
    end
    total++; if (done !== 1'b1) $display("FAIL bp_done: got %b exp 1", done); else passed++;
  endtask

  task automatic test_framing();
    do_reset();
    // Overlong message: 4 beats with no in_last -> error, not counted
    for (int b = 0; b < 4; b++) send_beat(16'h0000, 1'b0, 1'b0);
    total++; if (proto_err !== 1'b1 || ham_count !== 16'd0)
      $display("FAIL frame_overlong: got err=%b ham=%0d exp 1/0", proto_err, ham_count); else passed++;
    do_reset();
    // Short message: in_last on beat 1 -> error, still counted
    send_beat(16'hFFFF, 1'b0, 1'b0);
    send_beat(16'hFFFF, 1'b1, 1'b1);
    total++; if (proto_err !== 1'b1 || ham_count !== 16'd1 || spam_count !== 16'd0)
      $display("FAIL frame_short: got err=%b ham=%0d spam=%0d exp 1/1/0", proto_err, ham_count, spam_count);
    else passed++;
    // Next beat must be beat 0, so this label is latched as spam
    send_msg(1'b1, 16'h0FF0);
    total++; if (spam_count !== 16'd1) $display("FAIL frame_resync: got spam=%0d exp 1", spam_count); else passed++;
    readout();
    total++;
    if (rd_bits[0] !== 16'hFFFF || rd_bits[1] !== 16'hFFFF || rd_bits[2] !== 16'hAAAA || rd_bits[3] !== 16'hAAAA)
      $display("FAIL frame_ham_vec: got %h %h %h %h exp ffff ffff aaaa aaaa", rd_bits[0], rd_bits[1], rd_bits[2], rd_bits[3]);
    else passed++;
    total++;
    if (rd_bits[4] !== 16'h0FF0 || rd_bits[7] !== 16'h0FF0)
      $display("FAIL frame_spam_vec: got %h %h exp 0ff0", rd_bits[4], rd_bits[7]);
    else passed++;
  endtask

  task automatic test_clear();
    do_reset();
    send_msg(1'b0, 16'hFFFF);
    send_beat(16'hFFFF, 1'b1, 1'b1);
    total++; if (proto_err !== 1'b1 || ham_count !== 16'd1 || spam_count !== 16'd1)
      $display("FAIL clr_setup: got err=%b ham=%0d spam=%0d exp 1/1/1", proto_err, ham_count, spam_count);
    else passed++;
    out_ready = 1'b0;
    finalize = 1'b1;
    @(posedge clk); #1;
    finalize = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL clr_in_out: got %b exp 1", out_valid); else passed++;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    out_ready = 1'b1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL clr_abort: got valid=%b ready=%b exp 0/0", out_valid, in_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) $display("FAIL clr_busy[%0d]: got %b exp 0", i, in_ready); else passed++;
    end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL clr_ready: got %b exp 1", in_ready); else passed++;
    total++; if (ham_count !== 16'd0 || spam_count !== 16'd0 || proto_err !== 1'b0)
      $display("FAIL clr_state: got ham=%0d spam=%0d err=%b exp 0/0/0", ham_count, spam_count, proto_err);
    else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL clr_no_pending: got %b exp 0", out_valid); else passed++;
    readout();
    total++; if (rd_n !== 8 || rd_bits[0] !== 16'hAAAA || rd_bits[4] !== 16'hAAAA)
      $display("FAIL clr_counters: got n=%0d %h %h exp 8 aaaa aaaa", rd_n, rd_bits[0], rd_bits[4]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_empty_finalize();
    test_ham();
    test_spam();
    test_saturation();
    test_backpressure();
    test_framing();
    test_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
